float16_subtractor: RTL and testbench

Sequential sign-magnitude fixed-point subtractor computing `iNum1 - iNum2` in the same word format and reserved-code semantics as the datapath's combinational adder. It serves as the error/difference stage of the DNN update path. It processes magnitudes bit-serially (LSB first, one bit per cycle) behind valid/ready handshakes on both sides, trading latency for a single 1-bit borrow/carry cell.

---
 rtl/float16_subtractor.sv | 120 ++++++++++++
 tb/tb_float16_subtractor.sv | 104 ++++++++++
 2 files changed

// File: rtl/float16_subtractor.sv
// float16_subtractor: bit-serial sign-magnitude subtractor iNum1 - iNum2 with valid/ready handshakes.
// Define FLOAT16_SUB_SATURATE_EN to saturate arithmetic add overflow instead of emitting the marker.
module float16_subtractor #(
   parameter int bits = 8,
   localparam int W = 2*bits-1,
   localparam int M = W-1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] iNum1,
   input  logic [W-1:0] iNum2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] oNum,
   output logic         overflow,
   output logic         busy
);
   localparam int CW = $clog2(M+1);
   localparam logic [CW-1:0] CM = CW'(M);
   localparam logic [CW-1:0] CM1 = CW'(M-1);
   localparam logic [W-1:0] MARK = {1'b1, {M{1'b0}}};
   typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
   state_t state;
   logic [W-1:0] n1, n2, ovf_val;
   logic [M-1:0] a, b, acc, res1;
   logic [CW-1:0] cnt;
   logic c, s1, s2, sub, d, c_nxt, rn, mark1, mark2;
   assign s1 = n1[W-1];
   assign s2 = n2[W-1];
   assign sub = s1 == s2;
   assign mark1 = n1 == MARK;
   assign mark2 = n2 == MARK;
   assign d = a[0] ^ b[0] ^ c;
   assign c_nxt = sub ? ((~a[0] & b[0]) | (~(a[0] ^ b[0]) & c))
                      : ((a[0] & b[0]) | (a[0] & c) | (b[0] & c));
   assign res1 = {d, acc[M-1:1]};
   assign rn = ~acc[0] ^ c;
`ifdef FLOAT16_SUB_SATURATE_EN
   assign ovf_val = {s1, {M{1'b1}}};
`else
   assign ovf_val = MARK;
`endif
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         n1 <= '0;
         n2 <= '0;
         a <= '0;
         b <= '0;
         acc <= '0;
         cnt <= '0;
         c <= 1'b0;
         oNum <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               n1 <= iNum1;
               n2 <= iNum2;
               a <= iNum1[M-1:0];
               b <= iNum2[M-1:0];
               cnt <= '0;
               c <= 1'b0;
               state <= PASS1;
            end
            // cnt==0 is the special-case evaluation cycle; cnt 1..M carry one magnitude bit each
            PASS1: if (cnt == '0) begin
               if (n2 == '0) begin
                  oNum <= n1;
                  overflow <= 1'b0;
                  state <= DONE;
               end else if (n1 == '0) begin
                  oNum <= mark2 ? MARK : {~s2, n2[M-1:0]};
                  overflow <= mark2;
                  state <= DONE;
               end else if (mark1 || mark2) begin
                  oNum <= MARK;
                  overflow <= 1'b1;
                  state <= DONE;
               end else cnt <= cnt + 1'b1;
            end else begin
               a <= a >> 1;
               b <= b >> 1;
               acc <= res1;
               c <= c_nxt;
               if (cnt == CM) begin
                  if (!sub && c_nxt) begin
                     oNum <= ovf_val;
                     overflow <= 1'b1;
                     state <= DONE;
                  end else if (sub && c_nxt) begin
                     cnt <= '0;
                     c <= 1'b1;
                     state <= PASS2;
                  end else begin
                     oNum <= {s1 & |res1, res1};
                     overflow <= 1'b0;
                     state <= DONE;
                  end
               end else cnt <= cnt + 1'b1;
            end
            PASS2: begin
               acc <= {rn, acc[M-1:1]};
               c <= ~acc[0] & c;
               if (cnt == CM1) begin
                  oNum <= {~s1, rn, acc[M-1:1]};
                  overflow <= 1'b0;
                  state <= DONE;
               end else cnt <= cnt + 1'b1;
            end
            DONE: if (out_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_float16_subtractor.sv
// tb_float16_subtractor: directed vectors with hand-computed results, latency, backpressure and mid-op reset.
module tb_float16_subtractor;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [14:0] iNum1 = '0, iNum2 = '0;
   logic in_ready, out_valid, overflow, busy;
   logic [14:0] oNum;
   int checks = 0, errors = 0;
   float16_subtractor dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .iNum1(iNum1), .iNum2(iNum2), .out_valid(out_valid), .out_ready(out_ready),
      .oNum(oNum), .overflow(overflow), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_onum"}, 32'(oNum), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask
   task automatic run(input string tag, input logic [14:0] a, input logic [14:0] b,
                      input logic [14:0] exp_o, input logic exp_ovf, input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      iNum1 = a;
      iNum2 = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
      iNum1 = ~a;
      iNum2 = ~b;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_onum"}, 32'(oNum), 32'(exp_o));
      check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1 check({tag, "_hold_onum"}, 32'(oNum), 32'(exp_o));
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
   endtask
   initial begin
      #12 reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;
      run("sub", 15'h0300, 15'h0100, 15'h0200, 1'b0, 15, 0);
      run("borrow", 15'h0100, 15'h0300, 15'h4200, 1'b0, 29, 0);
`ifdef FLOAT16_SUB_SATURATE_EN
      run("add_ovf", 15'h3000, 15'h5000, 15'h3FFF, 1'b1, 15, 0);
`else
      run("add_ovf", 15'h3000, 15'h5000, 15'h4000, 1'b1, 15, 0);
`endif
      run("zero_n1", 15'h0000, 15'h0005, 15'h4005, 1'b0, 1, 0);
      run("zero_n2", 15'h1234, 15'h0000, 15'h1234, 1'b0, 1, 0);
      run("mark_n1", 15'h4000, 15'h0001, 15'h4000, 1'b1, 1, 0);
      run("zero_mark", 15'h0000, 15'h4000, 15'h4000, 1'b1, 1, 0);
      run("equal", 15'h1234, 15'h1234, 15'h0000, 1'b0, 15, 0);
      run("equal_neg", 15'h5234, 15'h5234, 15'h0000, 1'b0, 15, 0);
      run("add", 15'h0001, 15'h4002, 15'h0003, 1'b0, 15, 0);
      run("add_max", 15'h1FFF, 15'h6000, 15'h3FFF, 1'b0, 15, 0);
      run("neg_borrow", 15'h4001, 15'h4005, 15'h0004, 1'b0, 29, 0);
      run("backpr", 15'h2000, 15'h1000, 15'h1000, 1'b0, 15, 10);
      run("after_bp", 15'h0007, 15'h0002, 15'h0005, 1'b0, 15, 0);
      @(negedge clk);
      in_valid = 1'b1;
      iNum1 = 15'h0100;
      iNum2 = 15'h0300;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 reset_vals("midrst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_valid", 32'(out_valid), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      run("fresh", 15'h0100, 15'h0300, 15'h4200, 1'b0, 29, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
